pipe_stage_skid: RTL and testbench

- Parametrised, generic pipeline-stage register. It is the successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data bundle and a control bundle between stages using a valid/ready handshake.
- A 2-entry skid buffer lets stalls propagate one register at a time, so there is no combinational ready path.
- Flush inserts a bubble whose control field is forced to zero. A saturating bubble counter feeds performance monitoring.

---
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline-stage register with a 2-entry skid buffer,
// flush-to-bubble support and a saturating bubble counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W              = 128,
  parameter int unsigned CTRL_W              = 10,
  parameter int unsigned CLEAR_DATA_ON_FLUSH = 0,
  parameter int unsigned CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   main_data, main_data_nxt, skid_data, skid_data_nxt;
  logic [CTRL_W-1:0]   main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
  logic [CNT_W-1:0]    bubble_nxt;
  logic                acc, take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      bubble_cnt <= '0;
    end else begin
      state      <= state_nxt;
      main_data  <= main_data_nxt;
      main_ctrl  <= main_ctrl_nxt;
      skid_data  <= skid_data_nxt;
      skid_ctrl  <= skid_ctrl_nxt;
      bubble_cnt <= bubble_nxt;
    end
  end

  // All outputs decode from registers only, so ready never depends on inputs.
  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
    out_data  = main_data;
    out_ctrl  = out_valid ? main_ctrl : '0;
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    acc           = in_valid & in_ready;
    take          = out_valid & out_ready;
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;

    bubble_nxt = bubble_cnt;
    if (!out_valid && out_ready && (bubble_cnt != '1))
      bubble_nxt = bubble_cnt + CNT_W'(1);

    if (flush) begin
      state_nxt     = EMPTY;
      main_ctrl_nxt = '0;
      skid_ctrl_nxt = '0;
      if (CLEAR_DATA_ON_FLUSH != 0) begin
        main_data_nxt = '0;
        skid_data_nxt = '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
            state_nxt     = ONE;
          end
        end
        ONE: begin
          if (acc && take) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end else if (acc) begin
            skid_data_nxt = in_data;
            skid_ctrl_nxt = in_ctrl;
            state_nxt     = TWO;
          end else if (take) begin
            main_ctrl_nxt = '0;
            state_nxt     = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
            state_nxt     = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table for handshake/flush
// behaviour plus hand-written bubble-saturation and async-reset sequences.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [127:0] in_data;
  logic [9:0]   in_ctrl;

  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [127:0] out_data0, out_data1;
  logic [9:0]   out_ctrl0, out_ctrl1;
  logic [1:0]   occ0, occ1;
  logic [3:0]   bub0;
  logic [15:0]  bub1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(128), .CTRL_W(10), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occ0), .bubble_cnt(bub0)
  );

  pipe_stage_skid #(.DATA_W(128), .CTRL_W(10), .CLEAR_DATA_ON_FLUSH(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
    .occupancy(occ1), .bubble_cnt(bub1)
  );

  typedef struct {
    logic         iv;
    logic [127:0] id;
    logic [9:0]   ic;
    logic         ordy;
    logic         fl;
    logic         ev;
    logic [127:0] ed;   // expected out_data, CLEAR_DATA_ON_FLUSH=0
    logic [127:0] ecd;  // expected out_data, CLEAR_DATA_ON_FLUSH=1
    logic [9:0]   ec;
    logic [1:0]   eo;
    logic         eir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [127:0] id, logic [9:0] ic, logic ordy,
                              logic fl, logic ev, logic [127:0] ed, logic [127:0] ecd,
                              logic [9:0] ec, logic [1:0] eo, logic eir);
    vec_t v;
    v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.ecd = ecd; v.ec = ec; v.eo = eo; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    // Pass-through: A5 then words 1..8 back-to-back, then drain.
    vecs.push_back(mk(1, 128'hA5, 10'h3FF, 1, 0, 1, 128'hA5, 128'hA5, 10'h3FF, 1, 1));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 128'(k), 10'(k), 1, 0, 1, 128'(k), 128'(k), 10'(k), 1, 1));
    vecs.push_back(mk(0, 128'h55, 10'h55, 1, 0, 0, 128'd8, 128'd8, 10'h0, 0, 1));
    // Backpressure: 1,2 stored, 3 held upstream, then released in order.
    vecs.push_back(mk(1, 128'd1, 10'd1, 1, 0, 1, 128'd1, 128'd1, 10'd1, 1, 1));
    vecs.push_back(mk(1, 128'd2, 10'd2, 0, 0, 1, 128'd1, 128'd1, 10'd1, 2, 0));
    vecs.push_back(mk(1, 128'd3, 10'd3, 0, 0, 1, 128'd1, 128'd1, 10'd1, 2, 0));
    vecs.push_back(mk(1, 128'd3, 10'd3, 1, 0, 1, 128'd2, 128'd2, 10'd2, 1, 1));
    vecs.push_back(mk(1, 128'd3, 10'd3, 1, 0, 1, 128'd3, 128'd3, 10'd3, 1, 1));
    vecs.push_back(mk(0, 128'h55, 10'h55, 1, 0, 0, 128'd3, 128'd3, 10'h0, 0, 1));
    // Flush while full (DEAD, 8) with word 9 offered.
    vecs.push_back(mk(1, 128'hDEAD, 10'h2A, 0, 0, 1, 128'hDEAD, 128'hDEAD, 10'h2A, 1, 1));
    vecs.push_back(mk(1, 128'd8, 10'd8, 0, 0, 1, 128'hDEAD, 128'hDEAD, 10'h2A, 2, 0));
    vecs.push_back(mk(1, 128'd9, 10'd9, 0, 1, 0, 128'hDEAD, 128'h0, 10'h0, 0, 1));
    vecs.push_back(mk(0, 128'd9, 10'd9, 1, 0, 0, 128'hDEAD, 128'h0, 10'h0, 0, 1));
    vecs.push_back(mk(1, 128'hB, 10'hB, 1, 0, 1, 128'hB, 128'hB, 10'hB, 1, 1));
    vecs.push_back(mk(0, 128'h0, 10'h0, 1, 0, 0, 128'hB, 128'hB, 10'h0, 0, 1));
    // Flush in ONE with a word offered and taken: D is dropped.
    vecs.push_back(mk(1, 128'hC, 10'hC, 0, 0, 1, 128'hC, 128'hC, 10'hC, 1, 1));
    vecs.push_back(mk(1, 128'hD, 10'hD, 1, 1, 0, 128'hC, 128'h0, 10'h0, 0, 1));
    vecs.push_back(mk(0, 128'h0, 10'h0, 1, 0, 0, 128'hC, 128'h0, 10'h0, 0, 1));

    // Reset state
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    #2;
    chk("rst_out_valid", 128'(out_valid0), 128'd0);
    chk("rst_out_ctrl",  128'(out_ctrl0),  128'd0);
    chk("rst_out_data",  out_data0,        128'd0);
    chk("rst_occupancy", 128'(occ0),       128'd0);
    chk("rst_in_ready",  128'(in_ready0),  128'd1);
    chk("rst_bubble0",   128'(bub0),       128'd0);
    chk("rst_bubble1",   128'(bub1),       128'd0);
    do_reset();

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; in_ctrl = vecs[i].ic;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i),  128'(out_valid0), 128'(vecs[i].ev));
      chk($sformatf("v%0d_out_data", i),   out_data0,        vecs[i].ed);
      chk($sformatf("v%0d_out_ctrl", i),   128'(out_ctrl0),  128'(vecs[i].ec));
      chk($sformatf("v%0d_occupancy", i),  128'(occ0),       128'(vecs[i].eo));
      chk($sformatf("v%0d_in_ready", i),   128'(in_ready0),  128'(vecs[i].eir));
      chk($sformatf("v%0d_clr_valid", i),  128'(out_valid1), 128'(vecs[i].ev));
      chk($sformatf("v%0d_clr_data", i),   out_data1,        vecs[i].ecd);
      chk($sformatf("v%0d_clr_ctrl", i),   128'(out_ctrl1),  128'(vecs[i].ec));
      chk($sformatf("v%0d_clr_occ", i),    128'(occ1),       128'(vecs[i].eo));
      chk($sformatf("v%0d_clr_ready", i),  128'(in_ready1),  128'(vecs[i].eir));
    end

    // Bubble counter saturation at 15 (CNT_W=4), survives flush, cleared by reset.
    do_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bubble_c%0d", i), 128'(bub0), 128'((i > 15) ? 15 : i));
    end
    chk("bubble_wide_20", 128'(bub1), 128'd20);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("bubble_after_flush", 128'(bub0), 128'd15);
    chk("bubble_wide_flush", 128'(bub1), 128'd21);
    #2 reset = 1'b1;
    #1;
    chk("bubble_after_reset", 128'(bub0), 128'd0);
    reset = 1'b0;

    // Async reset between edges with occupancy 2.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h77; in_ctrl = 10'h77;
    @(posedge clk); #1;
    in_data = 128'h78; in_ctrl = 10'h78;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_arst_occ", 128'(occ0), 128'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid0), 128'd0);
    chk("arst_out_ctrl",  128'(out_ctrl0),  128'd0);
    chk("arst_out_data",  out_data0,        128'd0);
    chk("arst_occupancy", 128'(occ0),       128'd0);
    chk("arst_in_ready",  128'(in_ready0),  128'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
